// File: rtl/scfifo_stream_reader.sv
// scfifo_stream_reader
//
// Read-side adapter for a single-clock, non-show-ahead FIFO (one-cycle read
// latency, read/dout/empty interface). Words are popped from the FIFO and
// presented as a valid/ready stream. A 2-entry output buffer, with reads
// issued against the buffer's free credit, sustains one word per clock with
// no bubbles and never drops a word.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous reset, active-high
//   fifo_dout  in   FIFO read data, valid the cycle after fifo_read
//   fifo_empty in   FIFO empty flag
//   fifo_read  out  FIFO read strobe (combinational)
//   m_data     out  stream data, straight from the buffer head register
//   m_valid    out  stream valid
//   m_ready    in   stream ready from the consumer
//   buf_cnt    out  words held in the buffer, 0..2
//   word_cnt   out  32-bit pop counter, wraps; present only when the macro
//                   SCFIFO_STREAM_READER_CNT_EN is defined
module scfifo_stream_reader #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  output logic          fifo_read,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [1:0]    buf_cnt
`ifdef SCFIFO_STREAM_READER_CNT_EN
  ,
  output logic [31:0]   word_cnt
`endif
);

  logic [DW-1:0] buf_q [2];
  logic [DW-1:0] buf_d [2];
  logic [1:0]    buf_cnt_q;
  logic [1:0]    buf_cnt_d;
  logic          inflight_q;
  logic          pop;
  logic [2:0]    credit;
  logic [1:0]    cnt_after_pop;

  assign m_valid = (buf_cnt_q != 2'd0);
  assign m_data  = buf_q[0];
  assign buf_cnt = buf_cnt_q;
  assign pop     = m_valid & m_ready;

  // Words already owned by this block after this edge: buffered plus the one
  // in flight from the FIFO, minus the one leaving now. pop implies
  // buf_cnt >= 1, so the 3-bit difference never wraps below zero.
  assign credit    = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_read = ~rst & ~fifo_empty & (credit < 3'd2);

  assign cnt_after_pop = buf_cnt_q - {1'b0, pop};

  always_comb begin
    buf_d[0]  = buf_q[0];
    buf_d[1]  = buf_q[1];
    if (pop) begin
      buf_d[0] = buf_q[1];
    end
    // The arriving word lands behind whatever is left after the pop.
    if (inflight_q) begin
      if (cnt_after_pop == 2'd0) begin
        buf_d[0] = fifo_dout;
      end else begin
        buf_d[1] = fifo_dout;
      end
    end
    buf_cnt_d = cnt_after_pop + {1'b0, inflight_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      buf_cnt_q  <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= fifo_read;
    end
  end

`ifdef SCFIFO_STREAM_READER_CNT_EN
  logic [31:0] word_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= 32'd0;
    end else if (pop) begin
      word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule
